// File: rtl/hamming1511_pkg.sv
// Shared constants and types for the Hamming(15,11) encoder, serializer and decoder.
// The serializer frame is one start bit, the 15-bit codeword LSB first, and one stop bit.
package hamming1511_pkg;

   localparam int CW_WIDTH   = 15;
   localparam int FRAME_BITS = 17;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } tx_state_e;

endpackage

// File: rtl/hamming1511_bit_timer.sv
// Bit-time counter: bit_tick is high on the last clock cycle of each serial bit-time.
// restart holds the count at zero so that the first bit of a frame gets its full length.
module hamming1511_bit_timer #(
   parameter int BIT_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic bit_tick
);

   localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   assign bit_tick = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || bit_tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hamming1511_tx_serializer.sv
// Serialises Hamming(15,11) codewords as 17-bit frames (start 0, bits LSB first, stop 1).
// A one-deep holding register lets the next word be accepted while a frame is on the line.
module hamming1511_tx_serializer
   import hamming1511_pkg::*;
#(
   parameter int BIT_CYCLES = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [CW_WIDTH-1:0] in_word,
   output logic                ser_out,
   output logic                busy,
   output logic                frame_done,
   output tx_state_e           dbg_state
);

   localparam logic [3:0] LAST_BIT = 4'(CW_WIDTH - 1);

   tx_state_e           state, state_n;
   logic [CW_WIDTH-1:0] shreg, shreg_n;
   logic [CW_WIDTH-1:0] hold_reg, hold_reg_n;
   logic                hold_full, hold_full_n;
   logic [3:0]          bit_idx, bit_idx_n;
   logic                bit_tick;
   logic                hs;
   logic                direct_load;
   logic                move_load;

   // Handshake: a word transfers on a rising edge where in_valid and in_ready are both high;
   // in_valid may be raised at any time, and in_ready reflects only an empty holding register.
   assign in_ready  = ~hold_full;
   assign hs        = in_valid & in_ready;
   assign busy      = (state != ST_IDLE);
   assign dbg_state = state;

   hamming1511_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_bit_timer (
      .clk      (clk),
      .rst      (rst),
      .restart  (state == ST_IDLE),
      .bit_tick (bit_tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         shreg     <= '0;
         hold_reg  <= '0;
         hold_full <= 1'b0;
         bit_idx   <= '0;
      end else begin
         state     <= state_n;
         shreg     <= shreg_n;
         hold_reg  <= hold_reg_n;
         hold_full <= hold_full_n;
         bit_idx   <= bit_idx_n;
      end
   end

   always_comb begin
      state_n     = state;
      shreg_n     = shreg;
      bit_idx_n   = bit_idx;
      frame_done  = 1'b0;
      direct_load = 1'b0;
      move_load   = 1'b0;

      case (state)
         ST_IDLE: begin
            if (hs) begin
               direct_load = 1'b1;
               state_n     = ST_START;
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_n   = ST_DATA;
               bit_idx_n = '0;
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               shreg_n = {1'b1, shreg[CW_WIDTH-1:1]};
               if (bit_idx == LAST_BIT) begin
                  state_n = ST_STOP;
               end else begin
                  bit_idx_n = bit_idx + 4'd1;
               end
            end
         end
         ST_STOP: begin
            if (bit_tick) begin
               frame_done = 1'b1;
               // A held word always precedes one arriving this cycle.
               if (hold_full) begin
                  move_load = 1'b1;
                  state_n   = ST_START;
               end else if (hs) begin
                  direct_load = 1'b1;
                  state_n     = ST_START;
               end else begin
                  state_n = ST_IDLE;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (direct_load) begin
         shreg_n = in_word;
      end else if (move_load) begin
         shreg_n = hold_reg;
      end
   end

   always_comb begin
      hold_reg_n  = hold_reg;
      hold_full_n = (hold_full & ~move_load) | (hs & ~direct_load);
      if (hs && !direct_load) begin
         hold_reg_n = in_word;
      end
   end

   always_comb begin
      ser_out = 1'b1;
      case (state)
         ST_START: ser_out = 1'b0;
         ST_DATA:  ser_out = shreg[0];
         default:  ser_out = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_hamming1511_tx_serializer.sv
// Directed bench for the Hamming(15,11) serializer: per-cycle frame table on a 2-cycle
// bit-time instance, multi-cycle corner sequences, and a random stream on a 1-cycle instance.
module tb_hamming1511_tx_serializer;
   import hamming1511_pkg::*;

   typedef struct {
      logic [14:0] word;
      logic [16:0] frame;
   } vec_t;

   logic        clk = 1'b0;
   logic        a_rst = 1'b1, b_rst = 1'b1;
   logic        a_in_valid = 1'b0, b_in_valid = 1'b0;
   logic [14:0] a_in_word = '0, b_in_word = '0;
   logic        a_in_ready, b_in_ready;
   logic        a_ser_out, b_ser_out;
   logic        a_busy, b_busy;
   logic        a_frame_done, b_frame_done;
   tx_state_e   a_state, b_state;

   int checks = 0;
   int failures = 0;

   logic [14:0] exp_q_a[$];
   logic [14:0] exp_q_b[$];

   int          mon_cnt[2];
   logic [16:0] mon_bits[2];
   int          fd_cnt[2];
   int          bc[2];

   vec_t tbl[6];

   hamming1511_tx_serializer #(.BIT_CYCLES(2)) dut_a (
      .clk        (clk),
      .rst        (a_rst),
      .in_valid   (a_in_valid),
      .in_ready   (a_in_ready),
      .in_word    (a_in_word),
      .ser_out    (a_ser_out),
      .busy       (a_busy),
      .frame_done (a_frame_done),
      .dbg_state  (a_state)
   );

   hamming1511_tx_serializer #(.BIT_CYCLES(1)) dut_b (
      .clk        (clk),
      .rst        (b_rst),
      .in_valid   (b_in_valid),
      .in_ready   (b_in_ready),
      .in_word    (b_in_word),
      .ser_out    (b_ser_out),
      .busy       (b_busy),
      .frame_done (b_frame_done),
      .dbg_state  (b_state)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // scoreboard deserialiser, one lane per DUT
   task automatic mon_step(input int d, input logic s, input logic b, input logic f, input logic r);
      if (r || !b) begin
         mon_cnt[d] = 0;
         return;
      end
      if ((mon_cnt[d] % bc[d]) == 0 && (mon_cnt[d] / bc[d]) < 17)
         mon_bits[d][mon_cnt[d] / bc[d]] = s;
      if (f) begin
         fd_cnt[d]++;
         chk($sformatf("frame_len_%0d", d), mon_cnt[d], 17 * bc[d] - 1);
         chk($sformatf("start_bit_%0d", d), {31'd0, mon_bits[d][0]}, 32'd0);
         chk($sformatf("stop_bit_%0d", d), {31'd0, mon_bits[d][16]}, 32'd1);
         if (d == 0) begin
            if (exp_q_a.size() == 0) fail_now("unexpected_frame_a");
            else chk("word_a", {17'd0, mon_bits[0][15:1]}, {17'd0, exp_q_a.pop_front()});
         end else begin
            if (exp_q_b.size() == 0) fail_now("unexpected_frame_b");
            else chk("word_b", {17'd0, mon_bits[1][15:1]}, {17'd0, exp_q_b.pop_front()});
         end
         mon_cnt[d] = 0;
      end else begin
         mon_cnt[d]++;
      end
   endtask

   always @(negedge clk) mon_step(0, a_ser_out, a_busy, a_frame_done, a_rst);
   always @(negedge clk) mon_step(1, b_ser_out, b_busy, b_frame_done, b_rst);

   // driver: offers w until accepted; leaves in_valid high on return
   task automatic send(input int d, input logic [14:0] w);
      int n;
      n = 0;
      if (d == 0) begin a_in_valid = 1'b1; a_in_word = w; end
      else begin b_in_valid = 1'b1; b_in_word = w; end
      while (!((d == 0) ? a_in_ready : b_in_ready) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) begin
         fail_now("send_timeout");
      end else begin
         step();
         if (d == 0) exp_q_a.push_back(w);
         else exp_q_b.push_back(w);
      end
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (((d == 0) ? a_busy : b_busy) && n < 1000) begin
         step();
         n++;
      end
      if (n >= 1000) fail_now("idle_timeout");
   endtask

   initial begin
      int fd_before;
      bc[0] = 2;
      bc[1] = 1;
      fd_cnt[0] = 0;
      fd_cnt[1] = 0;
      mon_cnt[0] = 0;
      mon_cnt[1] = 0;

      tbl[0] = '{word: 15'h2AAA, frame: 17'h15554};
      tbl[1] = '{word: 15'h7FFF, frame: 17'h1FFFE};
      tbl[2] = '{word: 15'h0001, frame: 17'h10002};
      tbl[3] = '{word: 15'h4321, frame: 17'h18642};
      tbl[4] = '{word: 15'h0000, frame: 17'h10000};
      tbl[5] = '{word: 15'h5A5A, frame: 17'h1B4B4};

      // reset state
      step();
      step();
      chk("rst_ser_a", a_ser_out, 1);
      chk("rst_busy_a", a_busy, 0);
      chk("rst_fd_a", a_frame_done, 0);
      chk("rst_ready_a", a_in_ready, 1);
      chk("rst_state_a", a_state, ST_IDLE);
      chk("rst_ser_b", b_ser_out, 1);
      chk("rst_ready_b", b_in_ready, 1);
      a_rst = 1'b0;
      b_rst = 1'b0;
      step();

      // per-cycle frame table
      for (int i = 0; i < 6; i++) begin
         send(0, tbl[i].word);
         a_in_valid = 1'b0;
         for (int b = 0; b < 17; b++) begin
            for (int c = 0; c < 2; c++) begin
               if (c == 0) a_in_word = 15'($urandom_range(0, 32767));
               chk($sformatf("v%0d_ser_b%0d", i, b), a_ser_out, tbl[i].frame[b]);
               chk($sformatf("v%0d_busy_b%0d", i, b), a_busy, 1);
               chk($sformatf("v%0d_fd_b%0d", i, b), a_frame_done, (b == 16 && c == 1) ? 1 : 0);
               step();
            end
         end
         chk($sformatf("v%0d_busy_end", i), a_busy, 0);
         chk($sformatf("v%0d_ser_end", i), a_ser_out, 1);
         chk($sformatf("v%0d_ready_end", i), a_in_ready, 1);
         step();
      end
      chk("table_frames", fd_cnt[0], 6);

      // back-to-back: no idle gap, in_ready low while holding
      send(0, 15'h7FFF);
      send(0, 15'h0001);
      a_in_valid = 1'b0;
      for (int n = 0; n < 100 && !a_frame_done; n++) begin
         chk("b2b_ready_held", a_in_ready, 0);
         step();
      end
      chk("b2b_fd_seen", a_frame_done, 1);
      chk("b2b_ready_at_fd", a_in_ready, 0);
      step();
      chk("b2b_start_ser", a_ser_out, 0);
      chk("b2b_start_busy", a_busy, 1);
      chk("b2b_ready_after_move", a_in_ready, 1);
      wait_idle(0);
      chk("b2b_q_empty", exp_q_a.size(), 0);

      // backpressure: third word only after the first frame_done
      step();
      fd_before = fd_cnt[0];
      send(0, 15'h1111);
      send(0, 15'h2222);
      send(0, 15'h3333);
      chk("bp_third_after_fd", fd_cnt[0] - fd_before, 1);
      a_in_valid = 1'b0;
      wait_idle(0);
      chk("bp_frames", fd_cnt[0] - fd_before, 3);
      chk("bp_q_empty", exp_q_a.size(), 0);

      // mid-frame reset during bit 7 with a word held
      step();
      fd_before = fd_cnt[0];
      send(0, 15'h1234);
      send(0, 15'h0F0F);
      a_in_valid = 1'b0;
      for (int n = 0; n < 16; n++) step();
      chk("mr_bit7", a_ser_out, 0);
      chk("mr_ready_pre", a_in_ready, 0);
      a_rst = 1'b1;
      #1;
      chk("mr_ser", a_ser_out, 1);
      chk("mr_ready", a_in_ready, 1);
      chk("mr_busy", a_busy, 0);
      chk("mr_fd", a_frame_done, 0);
      // no word is taken while rst is high
      a_in_valid = 1'b1;
      a_in_word = 15'h5555;
      step();
      step();
      a_in_valid = 1'b0;
      a_rst = 1'b0;
      step();
      chk("mr_no_accept", a_busy, 0);
      chk("mr_no_fd", fd_cnt[0] - fd_before, 0);
      void'(exp_q_a.pop_front());
      void'(exp_q_a.pop_front());
      send(0, 15'h4321);
      a_in_valid = 1'b0;
      wait_idle(0);
      chk("mr_next_frame", fd_cnt[0] - fd_before, 1);
      chk("mr_q_empty", exp_q_a.size(), 0);

      // one cycle per bit, random words and gaps
      step();
      fd_before = fd_cnt[1];
      for (int i = 0; i < 40; i++) begin
         int gap;
         send(1, 15'($urandom_range(0, 32767)));
         gap = $urandom_range(0, 3);
         if (gap != 0) begin
            b_in_valid = 1'b0;
            for (int g = 0; g < gap; g++) begin
               b_in_word = 15'($urandom_range(0, 32767));
               step();
            end
         end
      end
      b_in_valid = 1'b0;
      wait_idle(1);
      chk("rnd_frames", fd_cnt[1] - fd_before, 40);
      chk("rnd_q_empty", exp_q_b.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
